// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a PS/2 device with the standard inhibit/request
// handshake. Both lines are driven open-drain (oe=1 pulls the line low).
// Data bits are shifted on filtered falling edges of the device clock, and
// the device acknowledge is sampled on the 11th falling edge.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kclk_in,
  input  logic       kdata_in,
  output logic       kclk_oe,
  output logic       kdata_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t state, state_nxt;

  // Input conditioning: index 0 = kclk, index 1 = kdata
  logic [1:0]       sync1, sync2;
  logic [1:0]       filt;
  logic [FLT_W-1:0] flt_cnt [0:1];
  logic             kclk_f, kdata_f, kclk_f_q, fall;

  // Datapath registers and their next values
  logic [INH_W-1:0] inh_cnt, inh_nxt;
  logic [TO_W-1:0]  to_cnt, to_nxt;
  logic [3:0]       bit_cnt, bit_nxt;
  logic [7:0]       tx_byte, byte_nxt;
  logic             parity, par_nxt;
  logic             kclk_oe_nxt, kdata_oe_nxt;
  logic             done_nxt, error_nxt, ack_nxt;

  logic             capture;
  logic             inh_last;
  logic             timeout_hit;

  // Two-flop synchronizer for the asynchronous pin levels; idle bus reads high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {kdata_in, kclk_in};
      sync2 <= sync1;
    end
  end

  // Glitch filter: a new level is accepted only after FILTER_LEN equal samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt <= '1;
      for (int unsigned i = 0; i < 2; i++) begin
        flt_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign kclk_f  = filt[0];
  assign kdata_f = filt[1];

  // Previous filtered clock level, used to form the one-cycle fall strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kclk_f_q <= 1'b1;
    end else begin
      kclk_f_q <= kclk_f;
    end
  end

  assign fall = kclk_f_q & ~kclk_f;

  // done is held off tx_ready so a request coinciding with done is dropped
  assign tx_ready = (state == S_IDLE) && !done;
  assign busy     = (state != S_IDLE);
  assign capture  = tx_valid && tx_ready;
  assign inh_last = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));

  assign timeout_hit = ((state == S_REQUEST) || (state == S_SHIFT) ||
                        (state == S_ACK) || (state == S_WAIT_IDLE)) &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; timeout overrides any other transition
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (capture) state_nxt = S_INHIBIT;
      S_INHIBIT:   if (inh_last) state_nxt = S_REQUEST;
      S_REQUEST:   state_nxt = S_SHIFT;
      S_SHIFT:     if (fall && (bit_cnt == 4'd9)) state_nxt = S_ACK;
      S_ACK:       if (fall) state_nxt = S_WAIT_IDLE;
      S_WAIT_IDLE: if (kclk_f && kdata_f) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_nxt = S_IDLE;
    end
  end

  // Output and datapath next values; line drives are computed one cycle
  // ahead so the registered oe outputs line up with the state they belong to
  always_comb begin
    kclk_oe_nxt  = 1'b0;
    kdata_oe_nxt = 1'b0;
    done_nxt     = 1'b0;
    error_nxt    = 1'b0;
    ack_nxt      = ack_ok;
    bit_nxt      = bit_cnt;
    inh_nxt      = inh_cnt;
    to_nxt       = to_cnt;
    byte_nxt     = tx_byte;
    par_nxt      = parity;
    unique case (state)
      S_IDLE: begin
        if (capture) begin
          byte_nxt     = tx_data;
          par_nxt      = ~^tx_data;
          ack_nxt      = 1'b0;
          inh_nxt      = '0;
          kclk_oe_nxt  = 1'b1;
          kdata_oe_nxt = (INHIBIT_CYCLES <= 1);
        end
      end
      S_INHIBIT: begin
        if (inh_last) begin
          kclk_oe_nxt  = 1'b0;
          kdata_oe_nxt = 1'b1;
          to_nxt       = '0;
          bit_nxt      = '0;
        end else begin
          kclk_oe_nxt  = 1'b1;
          kdata_oe_nxt = (inh_cnt == INH_W'(INHIBIT_CYCLES - 2));
          inh_nxt      = inh_cnt + 1'b1;
        end
      end
      S_REQUEST: begin
        kdata_oe_nxt = 1'b1;
        to_nxt       = to_cnt + 1'b1;
      end
      S_SHIFT: begin
        kdata_oe_nxt = kdata_oe;
        to_nxt       = to_cnt + 1'b1;
        if (fall) begin
          bit_nxt = bit_cnt + 1'b1;
          if (bit_cnt < 4'd8) begin
            kdata_oe_nxt = ~tx_byte[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            kdata_oe_nxt = ~parity;
          end else begin
            kdata_oe_nxt = 1'b0;
          end
        end
      end
      S_ACK: begin
        to_nxt = to_cnt + 1'b1;
        if (fall) begin
          ack_nxt = ~kdata_f;
        end
      end
      S_WAIT_IDLE: begin
        to_nxt = to_cnt + 1'b1;
        if (kclk_f && kdata_f) begin
          done_nxt = 1'b1;
        end
      end
      default: begin
        kdata_oe_nxt = 1'b0;
      end
    endcase
    if (timeout_hit) begin
      kclk_oe_nxt  = 1'b0;
      kdata_oe_nxt = 1'b0;
      error_nxt    = 1'b1;
      done_nxt     = 1'b0;
      ack_nxt      = 1'b0;
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kclk_oe  <= 1'b0;
      kdata_oe <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      ack_ok   <= 1'b0;
      bit_cnt  <= '0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      tx_byte  <= '0;
      parity   <= 1'b0;
    end else begin
      kclk_oe  <= kclk_oe_nxt;
      kdata_oe <= kdata_oe_nxt;
      done     <= done_nxt;
      error    <= error_nxt;
      ack_ok   <= ack_nxt;
      bit_cnt  <= bit_nxt;
      inh_cnt  <= inh_nxt;
      to_cnt   <= to_nxt;
      tx_byte  <= byte_nxt;
      parity   <= par_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model drives the clock and
// acknowledge; expected responses are queued at stimulus time and checked
// by a monitor whenever done or error pulses.
module tb_ps2_host_tx;

  localparam int INH  = 30;
  localparam int FLT  = 4;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, kclk_oe, kdata_oe, busy, done, ack_ok, error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       kclk_line, kdata_line;

  assign kclk_line  = ~kclk_oe & ~dev_clk_low;
  assign kdata_line = ~kdata_oe & ~dev_data_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .kclk_in (kclk_line),
    .kdata_in(kdata_line),
    .kclk_oe (kclk_oe),
    .kdata_oe(kdata_oe),
    .busy    (busy),
    .done    (done),
    .ack_ok  (ack_ok),
    .error   (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic is_err;
    logic ack;
  } resp_t;

  resp_t      exp_q[$];
  logic [8:0] bus_q[$];   // {parity, byte} the device must receive

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && (done || error)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual done=%0b error=%0b expected none", done, error);
      end else begin
        e = exp_q.pop_front();
        check("resp_done", done, !e.is_err);
        check("resp_error", error, e.is_err);
        check("resp_ack_ok", ack_ok, e.ack);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_request(output logic ok);
    int n = 0;
    while (!(busy && !kclk_oe && kdata_oe) && n < 500) begin
      @(negedge clk);
      n++;
    end
    ok = busy && !kclk_oe && kdata_oe;
    check("request_seen", ok, 1);
  endtask

  // Device side of one frame; glitch_clk selects a clock whose high phase
  // carries a FLT-1 cycle low glitch (0 = none)
  task automatic dev_frame(input logic ack, input int glitch_clk);
    logic [9:0] bits;
    logic [8:0] e;
    logic       ok;
    bits = '0;
    wait_request(ok);
    if (!ok) return;
    check("start_bit", kdata_line, 0);
    repeat (30) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (10) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k <= 10) bits[k-1] = kdata_line;
      dev_clk_low = 1'b0;
      if (k == 11) dev_data_low = 1'b0;
      if (k == glitch_clk) begin
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (FLT - 1) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - 5 - (FLT - 1)) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    if (bus_q.size() == 0) begin
      check("bus_expect_present", 0, 1);
    end else begin
      e = bus_q.pop_front();
      check("frame_data", bits[7:0], e[7:0]);
      check("frame_parity", bits[8], e[8]);
      check("frame_stop", bits[9], 1);
    end
  endtask

  task automatic timeout_test();
    int n = 0;
    int cyc = 0;
    while (!kclk_oe && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_seen", kclk_oe, 1);
    n = 0;
    while (kclk_oe && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("release_seen", kclk_oe, 0);
    while (!error && cyc < TO + 50) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_latency", cyc, TO);
    check("timeout_kclk_rel", kclk_oe, 0);
    check("timeout_kdata_rel", kdata_oe, 0);
    check("timeout_ready", tx_ready, 1);
  endtask

  task automatic reset_mid_frame();
    logic ok;
    wait_request(ok);
    if (!ok) return;
    repeat (30) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k < 5) begin
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
    // 0xAA bit 4 is 0, so the host must be pulling data low at n=5
    check("n5_kdata_oe", kdata_oe, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_kclk_oe", kclk_oe, 0);
    check("rst_kdata_oe", kdata_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst_n = 1'b1;
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic stray_requests();
    int n = 0;
    repeat (150) @(negedge clk);
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    int busy_seen;
    repeat (3) @(negedge clk);
    check("reset_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_kclk_oe", kclk_oe, 0);
    check("reset_kdata_oe", kdata_oe, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_ack_ok", ack_ok, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED: data oe 0,1,0,0,1,0,0,0, parity 1, ACK
    exp_q.push_back('{is_err: 1'b0, ack: 1'b1});
    bus_q.push_back({1'b1, 8'hED});
    send(8'hED);
    dev_frame(1'b1, 0);
    repeat (10) @(negedge clk);
    check("ack_ok_hold", ack_ok, 1);

    // 0x01: parity 0, device NACKs
    exp_q.push_back('{is_err: 1'b0, ack: 1'b0});
    bus_q.push_back({1'b0, 8'h01});
    send(8'h01);
    dev_frame(1'b0, 0);
    repeat (10) @(negedge clk);

    // 0xFF with a short glitch on kclk during the shift
    exp_q.push_back('{is_err: 1'b0, ack: 1'b1});
    bus_q.push_back({1'b1, 8'hFF});
    send(8'hFF);
    dev_frame(1'b1, 3);
    repeat (10) @(negedge clk);

    // No device clocks: timeout
    exp_q.push_back('{is_err: 1'b1, ack: 1'b0});
    send(8'h3C);
    timeout_test();
    repeat (10) @(negedge clk);

    // Reset at n=5 of 0xAA, then a clean 0x55 frame
    send(8'hAA);
    reset_mid_frame();
    repeat (10) @(negedge clk);
    exp_q.push_back('{is_err: 1'b0, ack: 1'b1});
    bus_q.push_back({1'b1, 8'h55});
    send(8'h55);
    dev_frame(1'b1, 0);
    repeat (10) @(negedge clk);

    // 0x12 with tx_valid pulsed mid-frame and in the done cycle
    exp_q.push_back('{is_err: 1'b0, ack: 1'b1});
    bus_q.push_back({1'b1, 8'h12});
    send(8'h12);
    fork
      dev_frame(1'b1, 0);
      stray_requests();
    join
    busy_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("no_extra_frame", busy_seen, 0);

    check("resp_queue_drained", exp_q.size(), 0);
    check("bus_queue_drained", bus_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
